// File: rtl/seletor_operador_if.sv
// Key inputs and operator outputs of the ULA operator selector.
// The bench drives the keys through the master modport.
interface seletor_operador_if;
  logic       btn_next;
  logic       btn_prev;
  logic       btn_confirm;
  logic [2:0] op_sel;
  logic [2:0] op_lock;
  logic       locked;
  logic       confirm_pulse;

  modport master (
    output btn_next, btn_prev, btn_confirm,
    input  op_sel, op_lock, locked, confirm_pulse
  );

  modport slave (
    input  btn_next, btn_prev, btn_confirm,
    output op_sel, op_lock, locked, confirm_pulse
  );
endinterface

// File: rtl/seletor_operador.sv
// ULA operator selector: debounces three active-low keys, steps a 3-bit operator code
// through 000..110, and latches it as the active operation on confirm.
module seletor_operador #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input logic               clk,
  input logic               rst_n,
  seletor_operador_if.slave bus
);
  localparam int unsigned CntW  = $clog2(DEB_CYCLES + 1);
  localparam logic [2:0]  OpMax = 3'b110;

  typedef enum logic {SELECT = 1'b0, LOCKED = 1'b1} state_t;

  logic [2:0] rawBtn;
  logic [2:0] pressEvt;

  assign rawBtn = {bus.btn_confirm, bus.btn_prev, bus.btn_next};

  for (genvar b = 0; b < 3; b++) begin : g_btn
    logic            sync1_q;
    logic            sync2_q;
    logic [1:0]      syncValid_q;
    logic            level_q;
    logic            levelDly_q;
    logic            armed_q;
    logic [CntW-1:0] cnt_q;

    // A key only arms once a genuine released level has come through the synchronizer,
    // so a key held across reset cannot fire until it is released and pressed again.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q     <= 1'b1;
        sync2_q     <= 1'b1;
        syncValid_q <= 2'b00;
        level_q     <= 1'b1;
        levelDly_q  <= 1'b1;
        armed_q     <= 1'b0;
        cnt_q       <= '0;
      end else begin
        sync1_q     <= rawBtn[b];
        sync2_q     <= sync1_q;
        syncValid_q <= {syncValid_q[0], 1'b1};
        levelDly_q  <= level_q;
        if (syncValid_q[1] && sync2_q) begin
          armed_q <= 1'b1;
        end
        if (sync2_q == level_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CntW'(DEB_CYCLES)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end
    end

    assign pressEvt[b] = levelDly_q & ~level_q & armed_q;
  end

  state_t     state_q, state_d;
  logic [2:0] opSel_q, opSel_d;
  logic [2:0] opLock_q, opLock_d;
  logic       locked_q, locked_d;
  logic       pulse_q, pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= SELECT;
      opSel_q  <= 3'b000;
      opLock_q <= 3'b000;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      opSel_q  <= opSel_d;
      opLock_q <= opLock_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
    end
  end

  // Confirm wins over next/prev in the same cycle; next and prev together cancel.
  always_comb begin
    state_d  = state_q;
    opSel_d  = opSel_q;
    opLock_d = opLock_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    case (state_q)
      SELECT: begin
        if (pressEvt[2]) begin
          opLock_d = opSel_q;
          locked_d = 1'b1;
          pulse_d  = 1'b1;
          state_d  = LOCKED;
        end else if (pressEvt[0] && !pressEvt[1]) begin
          opSel_d = (opSel_q == OpMax) ? 3'b000 : opSel_q + 3'd1;
        end else if (pressEvt[1] && !pressEvt[0]) begin
          opSel_d = (opSel_q == 3'b000) ? OpMax : opSel_q - 3'd1;
        end
      end
      LOCKED: begin
        if (pressEvt[2]) begin
          locked_d = 1'b0;
          state_d  = SELECT;
        end
      end
      default: begin
        state_d = SELECT;
      end
    endcase
  end

  assign bus.op_sel        = opSel_q;
  assign bus.op_lock       = opLock_q;
  assign bus.locked        = locked_q;
  assign bus.confirm_pulse = pulse_q;
endmodule

// File: doc/seletor_operador.md
# seletor_operador

Operator-selection front end for the ULA. It debounces three raw push-buttons and keeps a 3-bit operator code that steps through the seven valid codes, 000 (soma) to 110 (div). On confirm it latches that code as the active ULA operation. `op_sel` drives the operator 7-segment decoder directly, and `op_lock` feeds the ULA operation select.

## Interface
- `DEB_CYCLES`, default 50000: consecutive stable cycles before a button level is accepted. Minimum 2. Use 4 in simulation.
- `clk` input 1: system clock. Every register updates on its rising edge.
- `rst_n` input 1: one clock; reset is asynchronous and active-low.
- `btn_next` input 1: raw key, active-low (0 = pressed), asynchronous to `clk`.
- `btn_prev` input 1: raw key, active-low, asynchronous.
- `btn_confirm` input 1: raw key, active-low, asynchronous.
- `op_sel` output 3: operator currently shown. Goes to the 7-segment operator decoder.
- `op_lock` output 3: confirmed operator for the ULA.
- `locked` output 1: 1 while a confirmed operator is held.
- `confirm_pulse` output 1: single-cycle strobe when `op_lock` is loaded.

## Operation
- Input conditioning, applied to each button independently:
  - 2-flop synchronizer, then a debouncer.
  - Debouncer: a counter of width ceil(log2(DEB_CYCLES+1)) runs while the synchronized value differs from the debounced level. It clears whenever the two agree.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synchronized value.
  - Press event: a one-cycle internal strobe when the debounced level goes 1→0. Release produces no event. A held key produces exactly one event.
- FSM with two states, SELECT and LOCKED. Reset state is SELECT.
- Events in SELECT:
  - next: `op_sel` = `op_sel`+1. 110 wraps to 000.
  - prev: `op_sel` = `op_sel`−1. 000 wraps to 110.
  - confirm: `op_lock` ← `op_sel`, `locked` ← 1, `confirm_pulse` = 1 for one cycle, go to LOCKED.
- Events in LOCKED:
  - next and prev are ignored. `op_sel` and `op_lock` hold.
  - confirm: `locked` ← 0, go to SELECT. No pulse; `op_lock` keeps its last value.
- Simultaneous events in the same cycle:
  - confirm has priority. Next/prev events in that cycle are discarded.
  - next together with prev, without confirm: no change.
- Code 111 is never produced on `op_sel` or `op_lock`. The block does not defend against an illegal internal state; reset is the only recovery.
- Reset mid-operation, which includes mid-debounce: all counters, synchronizers and the FSM return to reset values. A key still held after reset deasserts produces no event until it has been released and pressed again.

## Timing
- Reset values:
  - `op_sel` = 000, `op_lock` = 000, `locked` = 0, `confirm_pulse` = 0.
  - FSM = SELECT.
  - Synchronizer flops and debounced levels = 1 (released); counters = 0.
- Latency:
  - A raw level held stable from edge k onward updates `op_sel`, `op_lock` and `locked` at edge k+DEB_CYCLES+3.
  - `confirm_pulse` is high during the cycle that follows that edge.
- Glitches: a raw level held for fewer than DEB_CYCLES cycles after synchronization produces no event.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Minimum spacing between events on one key: 2×(DEB_CYCLES+1) cycles, covering one press plus one release.

## Test plan
- Reset, then press `btn_next` 7 times with DEB_CYCLES=4 → `op_sel` steps 001, 010, 011, 100, 101, 110, 000. Each step occurs at DEB_CYCLES+3 cycles after the press; 111 never appears.
- From reset, press `btn_prev` once → `op_sel` = 110. Press it again → `op_sel` = 101.
- Set `op_sel` = 101, then press confirm → `op_lock` = 101, `locked` = 1, `confirm_pulse` high for exactly 1 cycle. Then press next → `op_sel` stays 101. Press confirm again → `locked` = 0, `op_lock` stays 101, no pulse.
- Bounce: pulse `btn_next` low for 3 cycles 5 times, then hold it low → exactly one increment. Releasing it produces no change.
- Force simultaneous debounced events in one cycle:
  - next + prev → no change.
  - next + confirm in SELECT → confirm applied and `op_sel` unchanged.
- Assert `rst_n`=0 while `btn_confirm` is held mid-debounce, with `locked`=1 → all outputs return to reset values immediately. Releasing reset while the key is still held → no event until the key is released and pressed again.
